// File: rtl/frog_game_ctrl.sv
// ============================================================================
// Module   : frog_game_ctrl
// Purpose  : Frogger game sequencer. Turns key presses into grid-bounded move
//            pulses, tracks the frog position against the lane obstacle map,
//            and manages kills, lives, score, respawn hold-off and game-over.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frog_game_ctrl #(
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int START_COL   = 3,
    parameter int LIVES       = 3,
    parameter int RESPAWN_CYC = 4,
    parameter int SCORE_W     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      key_u,
    input  logic                      key_d,
    input  logic                      key_l,
    input  logic                      key_r,
    input  logic [ROWS*COLS-1:0]      lane_obst,
    output logic                      U,
    output logic                      D,
    output logic                      L,
    output logic                      R,
    output logic                      kill,
    output logic [$clog2(ROWS)-1:0]   frog_row,
    output logic [$clog2(COLS)-1:0]   frog_col,
    output logic [2:0]                lives,
    output logic [SCORE_W-1:0]        score,
    output logic                      win,
    output logic                      game_over
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int IDX_W = $clog2(ROWS * COLS);
    localparam int CNT_W = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;

    localparam logic [ROW_W-1:0]   TOP_ROW   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0]   RIGHT_COL = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]   START_POS = COL_W'(START_COL);
    localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(RESPAWN_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {
        S_PLAY    = 2'd0,
        S_RESPAWN = 2'd1,
        S_OVER    = 2'd2
    } state_t;

    state_t             state;
    logic [3:0]         key_hist;      // {u, d, l, r} levels from the previous edge
    logic [CNT_W-1:0]   respawn_cnt;

    logic [3:0]         keys;
    logic [3:0]         press;
    logic               single_press;
    logic [IDX_W-1:0]   obst_idx;
    logic               obst_hit;
    logic               at_top;
    logic               at_right;

    // Rising-edge key detection; only a lone press counts as a command
    always_comb begin
        keys         = {key_u, key_d, key_l, key_r};
        press        = keys & ~key_hist;
        single_press = (press == 4'b1000) || (press == 4'b0100) ||
                       (press == 4'b0010) || (press == 4'b0001);
    end

    // Obstacle lookup at the frog's current cell and grid-edge flags
    always_comb begin
        obst_idx = IDX_W'(frog_row) * IDX_W'(COLS) + IDX_W'(frog_col);
        obst_hit = lane_obst[obst_idx];
        at_top   = (frog_row == TOP_ROW);
        at_right = (frog_col == RIGHT_COL);
    end

    // Game state machine with registered pulses and position/lives/score
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_PLAY;
            key_hist    <= 4'b1111;
            respawn_cnt <= '0;
            U           <= 1'b0;
            D           <= 1'b0;
            L           <= 1'b0;
            R           <= 1'b0;
            kill        <= 1'b0;
            win         <= 1'b0;
            game_over   <= 1'b0;
            frog_row    <= '0;
            frog_col    <= START_POS;
            lives       <= LIVES_INIT;
            score       <= '0;
        end else begin
            // History always follows the keys, even while input is ignored
            key_hist <= keys;
            U        <= 1'b0;
            D        <= 1'b0;
            L        <= 1'b0;
            R        <= 1'b0;
            kill     <= 1'b0;
            win      <= 1'b0;

            case (state)
                S_PLAY: begin
                    if (obst_hit) begin
                        kill     <= 1'b1;
                        frog_row <= '0;
                        frog_col <= START_POS;
                        lives    <= lives - 3'd1;
                        if (lives == 3'd1) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state       <= S_RESPAWN;
                            respawn_cnt <= CNT_LOAD;
                        end
                    end else if (at_top) begin
                        kill        <= 1'b1;
                        win         <= 1'b1;
                        if (score != SCORE_MAX) begin
                            score <= score + 1'b1;
                        end
                        frog_row    <= '0;
                        frog_col    <= START_POS;
                        state       <= S_RESPAWN;
                        respawn_cnt <= CNT_LOAD;
                    end else if (single_press) begin
                        // Moves that would leave the grid are silently dropped
                        unique case (press)
                            4'b1000: if (!at_top) begin
                                U        <= 1'b1;
                                frog_row <= frog_row + 1'b1;
                            end
                            4'b0100: if (frog_row != '0) begin
                                D        <= 1'b1;
                                frog_row <= frog_row - 1'b1;
                            end
                            4'b0010: if (frog_col != '0) begin
                                L        <= 1'b1;
                                frog_col <= frog_col - 1'b1;
                            end
                            default: if (!at_right) begin
                                R        <= 1'b1;
                                frog_col <= frog_col + 1'b1;
                            end
                        endcase
                    end
                end

                S_RESPAWN: begin
                    if (respawn_cnt == '0) begin
                        state <= S_PLAY;
                    end else begin
                        respawn_cnt <= respawn_cnt - 1'b1;
                    end
                end

                S_OVER: begin
                    kill <= 1'b1;
                    if (single_press) begin
                        kill        <= 1'b0;
                        game_over   <= 1'b0;
                        lives       <= LIVES_INIT;
                        score       <= '0;
                        frog_row    <= '0;
                        frog_col    <= START_POS;
                        state       <= S_RESPAWN;
                        respawn_cnt <= CNT_LOAD;
                    end
                end

                default: begin
                    state <= S_PLAY;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
